// File: rtl/cpu_core_pkg.sv
// Shared constants and types for the multi-cycle RV32I core: opcodes, funct fields,
// FSM states, ALU operations and immediate formats.
package cpu_core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0]  F7_ALT       = 7'b0100000;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_WB, ST_HALT} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   imm_gen = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm_gen = {instr[31:12], 12'h000};
      IMM_J:   imm_gen = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_gen = 32'h0000_0000;
    endcase
  endfunction

  // alt selects SUB/SRA; SUB only exists in register-register form
  function automatic alu_op_t alu_op_from_funct(input logic [2:0] f3, input logic alt,
                                                input logic is_reg);
    case (f3)
      3'b000:  alu_op_from_funct = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_from_funct = ALU_SLL;
      3'b010:  alu_op_from_funct = ALU_SLT;
      3'b011:  alu_op_from_funct = ALU_SLTU;
      3'b100:  alu_op_from_funct = ALU_XOR;
      3'b101:  alu_op_from_funct = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_from_funct = ALU_OR;
      3'b111:  alu_op_from_funct = ALU_AND;
      default: alu_op_from_funct = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational RV32I ALU with equality / signed / unsigned compare flags for branches.
module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  // Result mux; shift amounts use the low five bits of b
  always_comb begin
    result = 32'h0000_0000;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'h0000_0000, lt};
      ALU_SLTU: result = {31'h0000_0000, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle RV32I core (FETCH/EXEC/MEM/WB). Optional macro CPU_CORE_HALT_EN makes
// EBREAK park the core in HALT until reset; otherwise EBREAK is a NOP.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] Instr_Addr,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] MEM_addr,
  output logic [31:0] MEM_WR_out,
  output logic [2:0]  MEM_type,
  output logic        MEM_rd_en,
  output logic        MEM_wr_en,
  input  logic [31:0] MEM_data
);

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, mem_addr_r, mem_wdata_r;
  logic [2:0]  mem_type_r;
  logic        mem_rd_en_r, mem_wr_en_r, is_load_r;
  logic [4:0]  rd_r;
  logic [31:0] regs_r [NUM_REGS];

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic        alt_s, halt_s;
  logic [31:0] rs1_val_s, rs2_val_s, pc_plus4_s;
  alu_op_t     alu_op_s;
  logic [31:0] alu_a_s, alu_b_s, alu_res_s;
  logic        eq_s, lt_s, ltu_s;
  logic        rd_we_s, is_load_s, is_store_s, br_taken_s;
  logic [31:0] rd_data_s, next_pc_s;

  assign opcode_s   = INSTRUCTION[6:0];
  assign rd_s       = INSTRUCTION[11:7];
  assign funct3_s   = INSTRUCTION[14:12];
  assign rs1_s      = INSTRUCTION[19:15];
  assign rs2_s      = INSTRUCTION[24:20];
  assign alt_s      = (INSTRUCTION[31:25] == F7_ALT);
  assign rs1_val_s  = regs_r[rs1_s];
  assign rs2_val_s  = regs_r[rs2_s];
  assign pc_plus4_s = pc_r + 32'd4;

`ifdef CPU_CORE_HALT_EN
  assign halt_s = (INSTRUCTION == INSTR_EBREAK);
`else
  assign halt_s = 1'b0;
`endif

  cpu_core_alu u_alu (
    .op     (alu_op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_res_s),
    .eq     (eq_s),
    .lt     (lt_s),
    .ltu    (ltu_s)
  );

  // ALU operand and operation selection
  always_comb begin
    alu_op_s = ALU_ADD;
    alu_a_s  = rs1_val_s;
    alu_b_s  = imm_gen(INSTRUCTION, IMM_I);
    case (opcode_s)
      OPC_LUI: begin
        alu_a_s = 32'h0000_0000;
        alu_b_s = imm_gen(INSTRUCTION, IMM_U);
      end
      OPC_AUIPC: begin
        alu_a_s = pc_r;
        alu_b_s = imm_gen(INSTRUCTION, IMM_U);
      end
      OPC_BRANCH: alu_b_s  = rs2_val_s;
      OPC_STORE:  alu_b_s  = imm_gen(INSTRUCTION, IMM_S);
      OPC_OP_IMM: alu_op_s = alu_op_from_funct(funct3_s, alt_s, 1'b0);
      OPC_OP: begin
        alu_b_s  = rs2_val_s;
        alu_op_s = alu_op_from_funct(funct3_s, alt_s, 1'b1);
      end
      default: alu_op_s = ALU_ADD;
    endcase
  end

  // Write-back value, next PC and memory-class decode
  always_comb begin
    rd_we_s    = 1'b0;
    rd_data_s  = alu_res_s;
    next_pc_s  = pc_plus4_s;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    br_taken_s = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: rd_we_s = 1'b1;
      OPC_JAL: begin
        rd_we_s   = 1'b1;
        rd_data_s = pc_plus4_s;
        next_pc_s = pc_r + imm_gen(INSTRUCTION, IMM_J);
      end
      OPC_JALR: begin
        rd_we_s   = 1'b1;
        rd_data_s = pc_plus4_s;
        next_pc_s = {alu_res_s[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        case (funct3_s)
          F3_BEQ:  br_taken_s = eq_s;
          F3_BNE:  br_taken_s = !eq_s;
          F3_BLT:  br_taken_s = lt_s;
          F3_BGE:  br_taken_s = !lt_s;
          F3_BLTU: br_taken_s = ltu_s;
          F3_BGEU: br_taken_s = !ltu_s;
          default: br_taken_s = 1'b0;
        endcase
        if (br_taken_s) next_pc_s = pc_r + imm_gen(INSTRUCTION, IMM_B);
        else            next_pc_s = pc_plus4_s;
      end
      OPC_LOAD:  is_load_s  = 1'b1;
      OPC_STORE: is_store_s = 1'b1;
      default:   rd_we_s    = 1'b0;
    endcase
  end

  // FSM next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: state_next_s = ST_EXEC;
      ST_EXEC: begin
        if (is_load_s || is_store_s) state_next_s = ST_MEM;
        else if (halt_s)             state_next_s = ST_HALT;
        else                         state_next_s = ST_FETCH;
      end
      ST_MEM: begin
        if (is_load_r) state_next_s = ST_WB;
        else           state_next_s = ST_FETCH;
      end
      ST_WB:   state_next_s = ST_FETCH;
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_FETCH;
    endcase
  end

  // State, PC, register file and registered memory interface
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_type_r  <= 3'b000;
      mem_rd_en_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      is_load_r   <= 1'b0;
      rd_r        <= 5'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      mem_rd_en_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      case (state_r)
        ST_EXEC: begin
          if (is_load_s || is_store_s) begin
            mem_addr_r  <= alu_res_s;
            mem_type_r  <= funct3_s;
            mem_wdata_r <= rs2_val_s;
            mem_rd_en_r <= is_load_s;
            mem_wr_en_r <= is_store_s;
            is_load_r   <= is_load_s;
            rd_r        <= rd_s;
          end else if (!halt_s) begin
            pc_r <= next_pc_s;
            if (rd_we_s && (rd_s != 5'd0)) regs_r[rd_s] <= rd_data_s;
          end
        end
        ST_MEM: if (!is_load_r) pc_r <= pc_plus4_s;
        ST_WB: begin
          pc_r <= pc_plus4_s;
          if (rd_r != 5'd0) regs_r[rd_r] <= MEM_data;
        end
        default: pc_r <= pc_r;
      endcase
    end
  end

  assign Instr_Addr = pc_r;
  assign MEM_addr   = mem_addr_r;
  assign MEM_WR_out = mem_wdata_r;
  assign MEM_type   = mem_type_r;
  assign MEM_rd_en  = mem_rd_en_r;
  assign MEM_wr_en  = mem_wr_en_r;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: instruction table with CPI/next-PC/memory-strobe
// expectations, plus hand sequences for reset-in-MEM and EBREAK.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_addr, instruction, mem_addr, mem_wr_out, mem_data;
  logic [2:0]  mem_type;
  logic        mem_rd_en, mem_wr_en;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [logic [31:0]];
  logic [7:0]  dmem [256];

  cpu_core dut (
    .CLK         (clk),
    .Reset       (reset),
    .Instr_Addr  (instr_addr),
    .INSTRUCTION (instruction),
    .MEM_addr    (mem_addr),
    .MEM_WR_out  (mem_wr_out),
    .MEM_type    (mem_type),
    .MEM_rd_en   (mem_rd_en),
    .MEM_wr_en   (mem_wr_en),
    .MEM_data    (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom.exists(instr_addr)) instruction <= rom[instr_addr];
    else                        instruction <= 32'h0000_0013;
  end

  always @(posedge clk) begin
    logic [7:0] a;
    a = mem_addr[7:0];
    if (mem_wr_en) begin
      dmem[a] <= mem_wr_out[7:0];
      if (mem_type[1:0] != 2'b00) dmem[a + 8'd1] <= mem_wr_out[15:8];
      if (mem_type[1:0] == 2'b10) begin
        dmem[a + 8'd2] <= mem_wr_out[23:16];
        dmem[a + 8'd3] <= mem_wr_out[31:24];
      end
    end
    if (mem_rd_en) begin
      case (mem_type)
        3'b000:  mem_data <= {{24{dmem[a][7]}}, dmem[a]};
        3'b100:  mem_data <= {24'h000000, dmem[a]};
        3'b001:  mem_data <= {{16{dmem[a + 8'd1][7]}}, dmem[a + 8'd1], dmem[a]};
        3'b101:  mem_data <= {16'h0000, dmem[a + 8'd1], dmem[a]};
        default: mem_data <= {dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]};
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cpi;
    logic [31:0] next_pc;
    logic [1:0]  mop;     // 0 none, 1 store, 2 load
    logic [31:0] maddr;
    logic [2:0]  mtype;
    logic [31:0] mdata;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    int n;
    int wr_cnt, rd_cnt, cyc, bad;
    logic [31:0] c_addr, c_data;
    logic [2:0]  c_type;

    vecs[0]  = '{32'h00, 32'h0050_0093, 2, 32'h04, 2'd0, 32'h0, 3'd0, 32'h0};         // ADDI x1,x0,5
    vecs[1]  = '{32'h04, 32'hFFD0_0113, 2, 32'h08, 2'd0, 32'h0, 3'd0, 32'h0};         // ADDI x2,x0,-3
    vecs[2]  = '{32'h08, 32'h0020_81B3, 2, 32'h0C, 2'd0, 32'h0, 3'd0, 32'h0};         // ADD x3,x1,x2
    vecs[3]  = '{32'h0C, 32'h0011_2233, 2, 32'h10, 2'd0, 32'h0, 3'd0, 32'h0};         // SLT x4,x2,x1
    vecs[4]  = '{32'h10, 32'h0011_32B3, 2, 32'h14, 2'd0, 32'h0, 3'd0, 32'h0};         // SLTU x5,x2,x1
    vecs[5]  = '{32'h14, 32'h0030_2423, 3, 32'h18, 2'd1, 32'd8, 3'b010, 32'd2};       // SW x3,8(x0)
    vecs[6]  = '{32'h18, 32'h0080_2303, 4, 32'h1C, 2'd2, 32'd8, 3'b010, 32'h0};       // LW x6,8(x0)
    vecs[7]  = '{32'h1C, 32'h0060_2623, 3, 32'h20, 2'd1, 32'd12, 3'b010, 32'd2};      // SW x6,12
    vecs[8]  = '{32'h20, 32'h0040_2823, 3, 32'h24, 2'd1, 32'd16, 3'b010, 32'd1};      // SW x4,16
    vecs[9]  = '{32'h24, 32'h0050_2A23, 3, 32'h28, 2'd1, 32'd20, 3'b010, 32'd0};      // SW x5,20
    vecs[10] = '{32'h28, 32'h0020_00A3, 3, 32'h2C, 2'd1, 32'd1, 3'b000, 32'hFFFF_FFFD}; // SB x2,1
    vecs[11] = '{32'h2C, 32'h0010_4383, 4, 32'h30, 2'd2, 32'd1, 3'b100, 32'h0};       // LBU x7,1
    vecs[12] = '{32'h30, 32'h0070_2C23, 3, 32'h34, 2'd1, 32'd24, 3'b010, 32'h0000_00FD}; // SW x7,24
    vecs[13] = '{32'h34, 32'h0000_9463, 2, 32'h3C, 2'd0, 32'h0, 3'd0, 32'h0};         // BNE x1,x0,+8
    vecs[14] = '{32'h3C, 32'h0000_8463, 2, 32'h40, 2'd0, 32'h0, 3'd0, 32'h0};         // BEQ x1,x0,+8
    vecs[15] = '{32'h40, 32'h0130_0493, 2, 32'h44, 2'd0, 32'h0, 3'd0, 32'h0};         // ADDI x9,x0,0x13
    vecs[16] = '{32'h44, 32'h0004_80E7, 2, 32'h12, 2'd0, 32'h0, 3'd0, 32'h0};         // JALR x1,0(x9)
    vecs[17] = '{32'h12, 32'h0010_2E23, 3, 32'h16, 2'd1, 32'd28, 3'b010, 32'h48};     // SW x1,28
    vecs[18] = '{32'h16, 32'h1234_5537, 2, 32'h1A, 2'd0, 32'h0, 3'd0, 32'h0};         // LUI x10
    vecs[19] = '{32'h1A, 32'h4011_5593, 2, 32'h1E, 2'd0, 32'h0, 3'd0, 32'h0};         // SRAI x11,x2,1
    vecs[20] = '{32'h1E, 32'h00B5_0633, 2, 32'h22, 2'd0, 32'h0, 3'd0, 32'h0};         // ADD x12,x10,x11
    vecs[21] = '{32'h22, 32'h02C0_2023, 3, 32'h26, 2'd1, 32'd32, 3'b010, 32'h1234_4FFE}; // SW x12,32
    vecs[22] = '{32'h26, 32'h0DA0_006F, 2, 32'h100, 2'd0, 32'h0, 3'd0, 32'h0};        // JAL x0,+0xDA

    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    for (int i = 0; i < NV; i++) rom[vecs[i].pc] = vecs[i].instr;
    mem_data = 32'h0;

    reset = 1'b0;
    @(negedge clk);
    check("rst_pc", instr_addr, 32'h0);
    check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      check($sformatf("pc_%0d", i), instr_addr, vecs[i].pc);
      cyc = 0; wr_cnt = 0; rd_cnt = 0;
      c_addr = 32'h0; c_data = 32'h0; c_type = 3'd0;
      while (instr_addr == vecs[i].pc && cyc < 12) begin
        if (mem_wr_en) begin wr_cnt++; c_addr = mem_addr; c_type = mem_type; c_data = mem_wr_out; end
        if (mem_rd_en) begin rd_cnt++; c_addr = mem_addr; c_type = mem_type; end
        @(negedge clk);
        cyc++;
      end
      check($sformatf("cpi_%0d", i), cyc, vecs[i].cpi);
      check($sformatf("next_pc_%0d", i), instr_addr, vecs[i].next_pc);
      check($sformatf("wr_cnt_%0d", i), wr_cnt, (vecs[i].mop == 2'd1) ? 32'd1 : 32'd0);
      check($sformatf("rd_cnt_%0d", i), rd_cnt, (vecs[i].mop == 2'd2) ? 32'd1 : 32'd0);
      if (vecs[i].mop != 2'd0) begin
        check($sformatf("maddr_%0d", i), c_addr, vecs[i].maddr);
        check($sformatf("mtype_%0d", i), {29'h0, c_type}, {29'h0, vecs[i].mtype});
        if (vecs[i].mop == 2'd1) check($sformatf("mdata_%0d", i), c_data, vecs[i].mdata);
      end
    end

    // Reset asserted while a store strobe is live
    rom[32'h0] = 32'h0030_2423;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!mem_wr_en && n < 8) begin @(negedge clk); n++; end
    check("rst_store_strobe_seen", {31'h0, mem_wr_en}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("rst_mid_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_mid_pc", instr_addr, 32'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    check("rst_mid_wdata", mem_wr_out, 32'h0);
    check("rst_mid_type", {29'h0, mem_type}, 32'h0);

    // EBREAK at reset PC
    rom[32'h0] = 32'h0010_0073;
    reset = 1'b1;
`ifdef CPU_CORE_HALT_EN
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_addr != 32'h0 || mem_wr_en || mem_rd_en) bad++;
    end
    check("halt_frozen_cycles_bad", bad, 32'h0);
`else
    bad = 0;
    repeat (2) @(negedge clk);
    check("ebreak_nop_pc", instr_addr, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
